// File: rtl/flags_counter_file_if.sv
// Bus bundle for the RX/RTR pending-packet counter file.
// The master side drives increments, flushes, reads and pop-ready; the slave side is the counter file.
interface flags_counter_file_if #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 3
);
    logic              rx_write_enable;
    logic [ADDR_W-1:0] rx_addr;
    logic              rtr_write_enable;
    logic [ADDR_W-1:0] rtr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_flag;
    logic [CNT_W-1:0]  rd_count;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_ready;
    logic              ovf_err;
    logic [ADDR_W-1:0] ovf_addr;

    modport master (
        output rx_write_enable, rx_addr, rtr_write_enable, rtr_addr, rd_addr, pend_ready,
        input  rd_flag, rd_count, pend_valid, pend_addr, ovf_err, ovf_addr
    );

    modport slave (
        input  rx_write_enable, rx_addr, rtr_write_enable, rtr_addr, rd_addr, pend_ready,
        output rd_flag, rd_count, pend_valid, pend_addr, ovf_err, ovf_addr
    );
endinterface

// File: rtl/flags_counter_file.sv
// Per-channel saturating pending-packet counters with flush, combinational read port,
// round-robin valid/ready pop port and a registered overflow pulse.
module flags_counter_file #(
    parameter int NUM_CH = 8,
    parameter int ADDR_W = $clog2(NUM_CH),
    parameter int CNT_W  = 3
) (
    input logic clk,
    input logic rst_n,
    flags_counter_file_if.slave bus
);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [ADDR_W:0]   NUM_CH_W = (ADDR_W+1)'(NUM_CH);
    localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(NUM_CH - 1);

    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] nz;
    logic [NUM_CH-1:0] sat_hit;
    logic [ADDR_W-1:0] rr_ptr;
    logic [ADDR_W-1:0] ovf_addr_q;
    logic              ovf_q;
    logic [ADDR_W-1:0] pend_addr_c;
    logic              pend_valid_c;
    logic [ADDR_W:0]   scan_sum;
    logic [ADDR_W-1:0] scan_idx;
    logic              pop;
    logic              rd_ok;

    // First non-empty channel starting at rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        pend_valid_c = 1'b0;
        pend_addr_c  = '0;
        scan_sum     = '0;
        scan_idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_sum = {1'b0, rr_ptr} + (ADDR_W+1)'(i);
            if (scan_sum >= NUM_CH_W) begin
                scan_sum = scan_sum - NUM_CH_W;
            end
            scan_idx = scan_sum[ADDR_W-1:0];
            if (!pend_valid_c && nz[scan_idx]) begin
                pend_valid_c = 1'b1;
                pend_addr_c  = scan_idx;
            end
        end
    end

    assign pop   = pend_valid_c & bus.pend_ready;
    assign rd_ok = ({1'b0, bus.rd_addr} < NUM_CH_W);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             inc_hit;
        logic             flush_hit;
        logic             pop_hit;
        logic [CNT_W-1:0] cnt_q;

        // Matching g implies the address is in range, so out-of-range writes fall through.
        assign inc_hit   = bus.rx_write_enable  && (bus.rx_addr  == ADDR_W'(g));
        assign flush_hit = bus.rtr_write_enable && (bus.rtr_addr == ADDR_W'(g));
        assign pop_hit   = pop && (pend_addr_c == ADDR_W'(g));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (flush_hit) begin
                cnt_q <= '0;
            end else if (inc_hit && !pop_hit) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (pop_hit && !inc_hit) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end

        assign cnt[g]     = cnt_q;
        assign nz[g]      = |cnt_q;
        assign sat_hit[g] = inc_hit && !flush_hit && !pop_hit && (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            ovf_q      <= 1'b0;
            ovf_addr_q <= '0;
        end else begin
            if (pop) begin
                rr_ptr <= (pend_addr_c == LAST_CH) ? '0 : pend_addr_c + ADDR_W'(1);
            end
            ovf_q <= |sat_hit;
            if (|sat_hit) begin
                ovf_addr_q <= bus.rx_addr;
            end
        end
    end

    assign bus.rd_count   = rd_ok ? cnt[bus.rd_addr] : '0;
    assign bus.rd_flag    = rd_ok && nz[bus.rd_addr];
    assign bus.pend_valid = pend_valid_c;
    assign bus.pend_addr  = pend_addr_c;
    assign bus.ovf_err    = ovf_q;
    assign bus.ovf_addr   = ovf_addr_q;
endmodule

// File: tb/tb_flags_counter_file.sv
// Bench for flags_counter_file: reference model feeds a scoreboard of registered
// overflow results, plus directed checks of the documented scenarios.
module tb_flags_counter_file;
    logic clk;
    logic rst_n;

    flags_counter_file_if #(.ADDR_W(3), .CNT_W(3)) bus ();

    flags_counter_file #(.NUM_CH(8), .ADDR_W(3), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int       m_cnt [8];
    int       m_rr;
    int       m_ovf;
    int       m_ovf_addr;
    logic [3:0] sb_q [$];
    int       pop_log [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_rr       = 0;
        m_ovf      = 0;
        m_ovf_addr = 0;
        sb_q.delete();
        sb_q.push_back(4'd0);
    endtask

    task automatic model_pend(output int v, output int a);
        v = 0;
        a = 0;
        for (int k = 0; k < 8; k++) begin
            if (v == 0 && m_cnt[(m_rr + k) % 8] != 0) begin
                v = 1;
                a = (m_rr + k) % 8;
            end
        end
    endtask

    task automatic model_step(input int rxwe, input int rxa, input int rtrwe, input int rtra, input int rdy);
        int v, a, ovf, pop;
        model_pend(v, a);
        pop = (v != 0 && rdy != 0) ? 1 : 0;
        ovf = 0;
        if (pop != 0) pop_log.push_back(a);
        for (int ch = 0; ch < 8; ch++) begin
            if (rtrwe != 0 && rtra == ch) begin
                m_cnt[ch] = 0;
            end else if (rxwe != 0 && rxa == ch && pop != 0 && a == ch) begin
                m_cnt[ch] = m_cnt[ch];
            end else if (rxwe != 0 && rxa == ch) begin
                if (m_cnt[ch] == 7) ovf = 1;
                else m_cnt[ch] = m_cnt[ch] + 1;
            end else if (pop != 0 && a == ch) begin
                m_cnt[ch] = m_cnt[ch] - 1;
            end
        end
        m_ovf = ovf;
        if (ovf != 0) m_ovf_addr = rxa;
        if (pop != 0) m_rr = (a + 1) % 8;
    endtask

    // One clock: drive at negedge, check pre-edge outputs, push post-edge expectation.
    task automatic cycle(input int rxwe, input int rxa, input int rtrwe, input int rtra,
                         input int rdy, input int rda);
        int v, a;
        logic [3:0] e;
        @(negedge clk);
        bus.rx_write_enable  = (rxwe != 0);
        bus.rx_addr          = 3'(rxa);
        bus.rtr_write_enable = (rtrwe != 0);
        bus.rtr_addr         = 3'(rtra);
        bus.pend_ready       = (rdy != 0);
        bus.rd_addr          = 3'(rda);
        #1;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("ovf_err", 32'(bus.ovf_err), 32'(e[3]));
            check_val("ovf_addr", 32'(bus.ovf_addr), 32'(e[2:0]));
        end
        model_pend(v, a);
        check_val("pend_valid", 32'(bus.pend_valid), 32'(v));
        check_val("pend_addr", 32'(bus.pend_addr), 32'(a));
        check_val("rd_count", 32'(bus.rd_count), 32'(m_cnt[rda]));
        check_val("rd_flag", 32'(bus.rd_flag), (m_cnt[rda] != 0) ? 32'd1 : 32'd0);
        model_step(rxwe, rxa, rtrwe, rtra, rdy);
        sb_q.push_back({(m_ovf != 0), 3'(m_ovf_addr)});
        @(posedge clk);
    endtask

    task automatic idle_inputs();
        bus.rx_write_enable  = 1'b0;
        bus.rx_addr          = '0;
        bus.rtr_write_enable = 1'b0;
        bus.rtr_addr         = '0;
        bus.pend_ready       = 1'b0;
        bus.rd_addr          = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic peek(input int ch, input int exp_cnt);
        bus.rd_addr = 3'(ch);
        #1;
        check_val("peek_count", 32'(bus.rd_count), 32'(exp_cnt));
        check_val("peek_flag", 32'(bus.rd_flag), (exp_cnt != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int exp_pops [4];
        exp_pops = '{1, 5, 6, 0};
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_val("rst_pend_valid", 32'(bus.pend_valid), 32'd0);
        check_val("rst_ovf_err", 32'(bus.ovf_err), 32'd0);
        check_val("rst_rd_count", 32'(bus.rd_count), 32'd0);
        do_reset();

        // Three increments on ch3
        for (int i = 0; i < 3; i++) cycle(1, 3, 0, 0, 0, 3);
        peek(3, 3);
        check_val("t1_pend_valid", 32'(bus.pend_valid), 32'd1);
        check_val("t1_pend_addr", 32'(bus.pend_addr), 32'd3);

        // Saturate ch3 and overflow, then inc+pop at MAX
        for (int i = 0; i < 4; i++) cycle(1, 3, 0, 0, 0, 3);
        cycle(1, 3, 0, 0, 0, 3);
        #1;
        check_val("t2_ovf_err", 32'(bus.ovf_err), 32'd1);
        check_val("t2_ovf_addr", 32'(bus.ovf_addr), 32'd3);
        cycle(0, 0, 0, 0, 0, 3);
        #1;
        check_val("t2_ovf_pulse_end", 32'(bus.ovf_err), 32'd0);
        cycle(1, 3, 0, 0, 1, 3);
        #1;
        check_val("t2_incpop_no_ovf", 32'(bus.ovf_err), 32'd0);
        peek(3, 7);
        cycle(0, 0, 1, 3, 0, 3);
        peek(3, 0);

        // Round-robin pops 1,5,6 then wrap to 0
        do_reset();
        cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 5, 0, 0, 0, 5);
        cycle(1, 6, 0, 0, 0, 6);
        pop_log.delete();
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        #1;
        check_val("t3_drained", 32'(bus.pend_valid), 32'd0);
        check_val("t3_pop_count", 32'(pop_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_log.size()) check_val("t3_pop_order", 32'(pop_log[i]), 32'(exp_pops[i]));
        end
        cycle(0, 0, 0, 0, 1, 0);

        // Flush beats simultaneous inc and pop; rr_ptr moves past ch2
        for (int i = 0; i < 4; i++) cycle(1, 2, 0, 0, 0, 2);
        peek(2, 4);
        cycle(1, 2, 1, 2, 1, 2);
        #1;
        check_val("t4_no_ovf", 32'(bus.ovf_err), 32'd0);
        peek(2, 0);
        cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 3, 0, 0, 0, 3);
        #1;
        check_val("t4_rr_ptr_3", 32'(bus.pend_addr), 32'd3);

        // Inc ch0, flush ch4, pop ch7 in one cycle
        do_reset();
        cycle(1, 6, 0, 0, 0, 6);
        cycle(1, 7, 0, 0, 0, 7);
        cycle(1, 7, 0, 0, 0, 7);
        cycle(0, 0, 0, 0, 1, 6);
        cycle(1, 4, 0, 0, 0, 4);
        cycle(1, 4, 0, 0, 0, 4);
        #1;
        check_val("t5_pend_addr_7", 32'(bus.pend_addr), 32'd7);
        cycle(1, 0, 1, 4, 1, 0);
        peek(0, 1);
        peek(4, 0);
        peek(7, 1);

        // Async reset between edges while ovf_err is high
        for (int i = 0; i < 8; i++) cycle(1, 5, 0, 0, 0, 5);
        #1;
        check_val("t6_ovf_before_rst", 32'(bus.ovf_err), 32'd1);
        check_val("t6_ovf_addr_before", 32'(bus.ovf_addr), 32'd5);
        @(negedge clk);
        idle_inputs();
        bus.rd_addr = 3'd5;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_pend_valid", 32'(bus.pend_valid), 32'd0);
        check_val("t6_rst_ovf_err", 32'(bus.ovf_err), 32'd0);
        check_val("t6_rst_ovf_addr", 32'(bus.ovf_addr), 32'd0);
        check_val("t6_rst_rd_count", 32'(bus.rd_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 6, 0, 0, 0, 6);
        cycle(1, 2, 0, 0, 0, 2);
        #1;
        check_val("t6_lowest_pending", 32'(bus.pend_addr), 32'd2);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            cycle(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 4) == 0) ? 1 : 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end
        cycle(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
